// File: rtl/psg_mix_dac.sv
// PSG output stage: ABC/ACB/mono mixer, click-free gain ramp and a
// first-order delta-sigma 1-bit DAC per side, with registered 10-bit PCM.
module psg_mix_dac #(
   parameter int         RAMP_DIV   = 4096,
   parameter logic [7:0] BEEP_LEVEL = 8'hFF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] CH_A,
   input  logic [7:0] CH_B,
   input  logic [7:0] CH_C,
   input  logic       BEEPER,
   input  logic [1:0] MODE,
   input  logic       MUTE,
   output logic [9:0] PCM_L,
   output logic [9:0] PCM_R,
   output logic       DAC_L,
   output logic       DAC_R,
   output logic [4:0] GAIN,
   output logic       BUSY
);

   typedef enum logic [1:0] {IDLE, FADE_IN, RUN, FADE_OUT} state_t;

   localparam int            CW        = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] RAMP_LOAD = CW'(RAMP_DIV - 1);

   state_t        state, state_nx;
   logic [4:0]    gain, gain_nx;
   logic [1:0]    mode_act, mode_act_nx;
   logic [CW-1:0] ramp_cnt;
   logic          tick;

   logic [9:0]  a10, b10, c10, bp10, b_half, c_half;
   logic [9:0]  mix_l_nx, mix_r_nx, mix_l, mix_r;
   logic [13:0] prod_l, prod_r;
   logic [10:0] acc_l, acc_r;
   logic        prod_unused;

   // Free-running gain-step timebase, deliberately independent of the FSM.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values, regardless of block ordering.
   always_ff @(posedge CLK) begin
      if (RESET) ramp_cnt <= RAMP_LOAD;
      else if (ramp_cnt == '0) ramp_cnt <= RAMP_LOAD;
      else ramp_cnt <= ramp_cnt - CW'(1);
   end

   assign tick = (ramp_cnt == '0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         gain     <= 5'd0;
         mode_act <= 2'b00;
      end else begin
         state    <= state_nx;
         gain     <= gain_nx;
         mode_act <= mode_act_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      gain_nx     = gain;
      mode_act_nx = mode_act;
      unique case (state)
         IDLE: begin
            gain_nx     = 5'd0;
            mode_act_nx = MODE;
            if (!MUTE) state_nx = FADE_IN;
         end
         FADE_IN: begin
            if (MUTE || (MODE != mode_act)) begin
               state_nx = FADE_OUT;
            end else if (tick) begin
               gain_nx = gain + 5'd1;
               if (gain >= 5'd15) state_nx = RUN;
            end
         end
         RUN: begin
            gain_nx = 5'd16;
            if (MUTE || (MODE != mode_act)) state_nx = FADE_OUT;
         end
         FADE_OUT: begin
            if (gain == 5'd0) state_nx = IDLE;
            else if (tick) gain_nx = gain - 5'd1;
         end
         default: begin
            state_nx = IDLE;
            gain_nx  = 5'd0;
         end
      endcase
   end

   assign a10    = {2'b00, CH_A};
   assign b10    = {2'b00, CH_B};
   assign c10    = {2'b00, CH_C};
   assign b_half = {3'b000, CH_B[7:1]};
   assign c_half = {3'b000, CH_C[7:1]};
   assign bp10   = BEEPER ? {2'b00, BEEP_LEVEL} : 10'd0;

   // Mixing follows mode_act, which only changes while the gain is zero.
   always_comb begin
      mix_l_nx = '0;
      mix_r_nx = '0;
      if (mode_act[1]) begin
         mix_l_nx = a10 + b10 + c10 + bp10;
         mix_r_nx = mix_l_nx;
      end else if (mode_act[0]) begin
         mix_l_nx = a10 + c_half + bp10;
         mix_r_nx = b10 + c_half + bp10;
      end else begin
         mix_l_nx = a10 + b_half + bp10;
         mix_r_nx = c10 + b_half + bp10;
      end
   end

   // Max product is 1020*16 = 16320, which fits 14 bits exactly.
   assign prod_l      = {4'b0000, mix_l} * {9'd0, gain};
   assign prod_r      = {4'b0000, mix_r} * {9'd0, gain};
   assign prod_unused = &{1'b0, prod_l[3:0], prod_r[3:0]};

   // NOTE: the pipeline and accumulators are plain registers, not memories,
   // so they are cleared on reset to give a silent, deterministic start.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mix_l <= '0;
         mix_r <= '0;
         PCM_L <= '0;
         PCM_R <= '0;
         acc_l <= '0;
         acc_r <= '0;
      end else begin
         mix_l <= mix_l_nx;
         mix_r <= mix_r_nx;
         PCM_L <= prod_l[13:4];
         PCM_R <= prod_r[13:4];
         acc_l <= {1'b0, acc_l[9:0]} + {1'b0, PCM_L};
         acc_r <= {1'b0, acc_r[9:0]} + {1'b0, PCM_R};
      end
   end

   // The carry out of each 10-bit accumulation is the 1-bit DAC output.
   assign DAC_L = acc_l[10];
   assign DAC_R = acc_r[10];
   assign GAIN  = gain;
   assign BUSY  = (state != RUN);

endmodule
